// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

  localparam int WS_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the processor ports, the arbiter and the single-port memory.
interface mem_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Arbiter view.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ready, d_rdata, d_ready,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Processor and memory view.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ready, d_rdata, d_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selector. MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-break;
// otherwise the data port always wins a tie.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  grant_t last_grant,
  output grant_t grant
);

  always_comb begin
    grant = GNT_D;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (if_req && d_req) begin
      grant = (last_grant == GNT_D) ? GNT_IF : GNT_D;
    end else if (if_req) begin
      grant = GNT_IF;
    end
`else
    if (if_req && !d_req) begin
      grant = GNT_IF;
    end
`endif
  end

`ifndef MEM_ARB_ROUND_ROBIN_EN
  // Fixed priority ignores history.
  logic unusedLastGrant;
  assign unusedLastGrant = last_grant;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between the fetch and data ports.
// Round-robin tie-break is built when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 11,
  parameter int WAIT_STATES = 0
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [WS_CNT_W-1:0] WS_INIT     = WS_CNT_W'(WAIT_STATES);
  localparam logic [WS_CNT_W-1:0] CNT_ONE     = WS_CNT_W'(1);
  localparam logic                WE_IN_FIRST = (WAIT_STATES == 0);

  state_t              state;
  logic [WS_CNT_W-1:0] waitCnt;
  grant_t              gnt;
  logic                latchedWe;
  logic                memEn;
  logic                memWe;
  logic [ADDR_W-1:0]   memAddr;
  logic [DATA_W-1:0]   memWdata;
  logic                ifReady;
  logic                dReady;
  logic [DATA_W-1:0]   ifRdataReg;
  logic [DATA_W-1:0]   dRdataReg;

  grant_t pick;
  grant_t lastGrant;
  logic   anyReq;
  logic   pickWe;

  assign anyReq = bus.if_req | bus.d_req;
  assign pickWe = (pick == GNT_D) & bus.d_we;

  mem_arb_pick uPick (
    .if_req     (bus.if_req),
    .d_req      (bus.d_req),
    .last_grant (lastGrant),
    .grant      (pick)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lastGrant <= GNT_IF;
    end else if (state == IDLE && anyReq) begin
      lastGrant <= pick;
    end
  end
`else
  assign lastGrant = GNT_IF;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      waitCnt    <= '0;
      gnt        <= GNT_D;
      latchedWe  <= 1'b0;
      memEn      <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWdata   <= '0;
      ifReady    <= 1'b0;
      dReady     <= 1'b0;
      ifRdataReg <= '0;
      dRdataReg  <= '0;
    end else begin
      ifReady <= 1'b0;
      dReady  <= 1'b0;
      case (state)
        // Grant and latch the request; the memory strobes are registered here.
        IDLE: begin
          if (anyReq) begin
            gnt       <= pick;
            latchedWe <= pickWe;
            memAddr   <= (pick == GNT_D) ? bus.d_addr : bus.if_addr;
            if (pick == GNT_D) begin
              memWdata <= bus.d_wdata;
            end
            memEn     <= 1'b1;
            memWe     <= pickWe & WE_IN_FIRST;
            waitCnt   <= WS_INIT;
            state     <= ACCESS;
          end
        end
        // Write strobe lands only in the last access cycle.
        ACCESS: begin
          if (waitCnt == '0) begin
            state <= RESP;
            memEn <= 1'b0;
            memWe <= 1'b0;
            if (gnt == GNT_D) begin
              dReady <= 1'b1;
            end else begin
              ifReady <= 1'b1;
            end
          end else begin
            waitCnt <= waitCnt - CNT_ONE;
            memWe   <= latchedWe & (waitCnt == CNT_ONE);
          end
        end
        // Read data arrives now; keep a copy for the hold-after-ready behaviour.
        RESP: begin
          state <= IDLE;
          if (!latchedWe) begin
            if (gnt == GNT_D) begin
              dRdataReg <= bus.mem_rdata;
            end else begin
              ifRdataReg <= bus.mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata  = ifReady ? bus.mem_rdata : ifRdataReg;
  assign bus.d_rdata   = (dReady && !latchedWe) ? bus.mem_rdata : dRdataReg;
  assign bus.if_ready  = ifReady;
  assign bus.d_ready   = dReady;
  assign bus.mem_en    = memEn;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: dutA runs with 2 wait states, dutB with 0; each has its own memory model.
module tb_mem_arbiter;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  typedef struct packed {
    logic [1:0]  dut;
    logic [1:0]  kind;   // 0 fetch ready, 1 data ready, 2 memory write
    logic [15:0] addr;
    logic [15:0] data;
    logic [31:0] cyc;
  } evt_t;

  logic clk = 1'b0;
  logic reset;
  logic memInit;
  int   cyc = 0;
  int   t0 = 0;
  int   vectors = 0;
  int   miscompares = 0;
  evt_t expQ[$];
  evt_t obsQ[$];

  logic [15:0] memA [0:2047];
  logic [15:0] memB [0:2047];

  mem_arbiter_if #(.DATA_W(16), .ADDR_W(11)) busA ();
  mem_arbiter_if #(.DATA_W(16), .ADDR_W(11)) busB ();

  mem_arbiter #(.DATA_W(16), .ADDR_W(11), .WAIT_STATES(WS_A)) dutA (
    .clk(clk), .reset(reset), .bus(busA)
  );
  mem_arbiter #(.DATA_W(16), .ADDR_W(11), .WAIT_STATES(WS_B)) dutB (
    .clk(clk), .reset(reset), .bus(busB)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] dflt(input logic [10:0] a);
    return 16'h5000 | {5'd0, a};
  endfunction

  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 2048; i++) memA[i] = dflt(11'(i));
    end else if (busA.mem_en) begin
      busA.mem_rdata <= memA[busA.mem_addr];
      if (busA.mem_we) memA[busA.mem_addr] = busA.mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (memInit) begin
      for (int i = 0; i < 2048; i++) memB[i] = dflt(11'(i));
    end else if (busB.mem_en) begin
      busB.mem_rdata <= memB[busB.mem_addr];
      if (busB.mem_we) memB[busB.mem_addr] = busB.mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (busA.if_ready) obsQ.push_back(evt_t'{2'd0, 2'd0, 16'd0, busA.if_rdata, 32'(cyc)});
    if (busA.d_ready)  obsQ.push_back(evt_t'{2'd0, 2'd1, 16'd0, busA.d_rdata, 32'(cyc)});
    if (busA.mem_we)   obsQ.push_back(evt_t'{2'd0, 2'd2, 16'(busA.mem_addr), busA.mem_wdata, 32'(cyc)});
    if (busB.if_ready) obsQ.push_back(evt_t'{2'd1, 2'd0, 16'd0, busB.if_rdata, 32'(cyc)});
    if (busB.d_ready)  obsQ.push_back(evt_t'{2'd1, 2'd1, 16'd0, busB.d_rdata, 32'(cyc)});
    if (busB.mem_we)   obsQ.push_back(evt_t'{2'd1, 2'd2, 16'(busB.mem_addr), busB.mem_wdata, 32'(cyc)});
  end

  task automatic startCycle();
    @(posedge clk);
    #1;
    t0 = cyc;
  endtask

  task automatic pushExp(input int dut, input int kind, input logic [15:0] addr,
                         input logic [15:0] data, input int k);
    expQ.push_back(evt_t'{2'(dut), 2'(kind), addr, data, 32'(t0 + k)});
  endtask

  task automatic fetchA(input logic [10:0] addr, input logic [15:0] expData);
    startCycle();
    busA.if_req = 1'b1;
    busA.if_addr = addr;
    pushExp(0, 0, 16'h0, expData, WS_A + 2);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busA.if_ready) busA.if_req = 1'b0;
    end
    busA.if_req = 1'b0;
  endtask

  task automatic dataA(input logic we, input logic [10:0] addr, input logic [15:0] wdata,
                       input logic [15:0] expRdata);
    startCycle();
    busA.d_req = 1'b1;
    busA.d_we = we;
    busA.d_addr = addr;
    busA.d_wdata = wdata;
    if (we) pushExp(0, 2, 16'(addr), wdata, WS_A + 1);
    pushExp(0, 1, 16'h0, expRdata, WS_A + 2);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busA.d_ready) begin
        busA.d_req = 1'b0;
        busA.d_we = 1'b0;
      end
    end
    busA.d_req = 1'b0;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busA.if_ready, busA.d_ready, busA.mem_en, busA.mem_we, busA.busy,
           busA.if_rdata, busA.d_rdata, busA.mem_addr, busA.mem_wdata} !== 80'd0) begin
        miscompares++;
        $display("FAIL reset_A cycle %0d: en %b we %b busy %b rdy %b%b addr %h, required all 0",
                 c, busA.mem_en, busA.mem_we, busA.busy, busA.if_ready, busA.d_ready, busA.mem_addr);
      end
      vectors++;
      if ({busB.if_ready, busB.d_ready, busB.mem_en, busB.mem_we, busB.busy,
           busB.if_rdata, busB.d_rdata, busB.mem_addr, busB.mem_wdata} !== 80'd0) begin
        miscompares++;
        $display("FAIL reset_B cycle %0d: en %b we %b busy %b rdy %b%b addr %h, required all 0",
                 c, busB.mem_en, busB.mem_we, busB.busy, busB.if_ready, busB.d_ready, busB.mem_addr);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    memInit = 1'b0;
    busA.if_req = 1'b0; busA.d_req = 1'b0; busA.d_we = 1'b0;
    busB.if_req = 1'b0; busB.d_req = 1'b0; busB.d_we = 1'b0;
    #1;
    vectors++;
    if (obsQ.size() != 0) begin
      miscompares++;
      $display("FAIL reset_events: got %0d events, required 0", obsQ.size());
      obsQ.delete();
    end
  endtask

  task automatic test_store();
    evt_t e, o;
    startCycle();
    busA.d_req = 1'b1; busA.d_we = 1'b1; busA.d_addr = 11'h005; busA.d_wdata = 16'hBEEF;
    pushExp(0, 2, 16'h005, 16'hBEEF, 3);
    pushExp(0, 1, 16'h0, 16'h0000, 4);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vectors++;
      if (busA.mem_en !== (k >= 1 && k <= 3)) begin
        miscompares++;
        $display("FAIL store_mem_en cycle %0d: got %b, required %b", k, busA.mem_en, (k >= 1 && k <= 3));
      end
      if (busA.d_ready) begin busA.d_req = 1'b0; busA.d_we = 1'b0; end
    end
    #1;
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      vectors++;
      if (obsQ.size() == 0) begin
        miscompares++;
        $display("FAIL store_evt: got nothing, required %h", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL store_evt: got %h, required %h", o, e); end
      end
    end
    vectors++;
    if (obsQ.size() != 0) begin
      miscompares++;
      $display("FAIL store_extra: got %0d extra events (first %h), required 0", obsQ.size(), obsQ[0]);
      obsQ.delete();
    end
  endtask

  task automatic test_fetch();
    evt_t e, o;
    dataA(1'b1, 11'h010, 16'h1234, 16'h0000);
    fetchA(11'h010, 16'h1234);
    vectors++;
    if (busA.if_rdata !== 16'h1234) begin
      miscompares++;
      $display("FAIL fetch_hold: got %h, required 1234", busA.if_rdata);
    end
    #1;
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      vectors++;
      if (obsQ.size() == 0) begin
        miscompares++;
        $display("FAIL fetch_evt: got nothing, required %h", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL fetch_evt: got %h, required %h", o, e); end
      end
    end
    vectors++;
    if (obsQ.size() != 0) begin
      miscompares++;
      $display("FAIL fetch_extra: got %0d extra events (first %h), required 0", obsQ.size(), obsQ[0]);
      obsQ.delete();
    end
  endtask

  task automatic test_reset_mid_access();
    evt_t e, o;
    // Load aborted in its second access cycle.
    startCycle();
    busA.d_req = 1'b1; busA.d_we = 1'b0; busA.d_addr = 11'h001;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    busA.d_req = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busA.busy, busA.mem_en, busA.d_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_load: busy/en/ready got %b, required 000", {busA.busy, busA.mem_en, busA.d_ready});
    end
    // Store aborted in its final access cycle: the strobed write still lands.
    startCycle();
    busA.d_req = 1'b1; busA.d_we = 1'b1; busA.d_addr = 11'h020; busA.d_wdata = 16'hCAFE;
    pushExp(0, 2, 16'h020, 16'hCAFE, 3);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    busA.d_req = 1'b0; busA.d_we = 1'b0;
    @(negedge clk);
    vectors++;
    if ({busA.busy, busA.mem_we, busA.d_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_store: busy/we/ready got %b, required 000", {busA.busy, busA.mem_we, busA.d_ready});
    end
    fetchA(11'h020, 16'hCAFE);
    fetchA(11'h002, 16'h5002);
    #1;
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      vectors++;
      if (obsQ.size() == 0) begin
        miscompares++;
        $display("FAIL abort_evt: got nothing, required %h", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL abort_evt: got %h, required %h", o, e); end
      end
    end
    vectors++;
    if (obsQ.size() != 0) begin
      miscompares++;
      $display("FAIL abort_extra: got %0d extra events (first %h), required 0", obsQ.size(), obsQ[0]);
      obsQ.delete();
    end
  endtask

  task automatic test_contention();
    evt_t e, o;
    int nAcc;
    startCycle();
    busB.if_req = 1'b1; busB.if_addr = 11'h003;
    busB.d_req = 1'b1; busB.d_we = 1'b0; busB.d_addr = 11'h004;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pushExp(1, 1, 16'h0, 16'h5004, 2);
    pushExp(1, 0, 16'h0, 16'h5003, 5);
    pushExp(1, 1, 16'h0, 16'h5004, 8);
    pushExp(1, 0, 16'h0, 16'h5003, 11);
`else
    pushExp(1, 1, 16'h0, 16'h5004, 2);
    pushExp(1, 1, 16'h0, 16'h5004, 5);
    pushExp(1, 1, 16'h0, 16'h5004, 8);
    pushExp(1, 1, 16'h0, 16'h5004, 11);
    pushExp(1, 0, 16'h0, 16'h5003, 14);
`endif
    nAcc = 0;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (busB.if_ready || busB.d_ready) nAcc++;
      if (nAcc >= 4) begin
        busB.d_req = 1'b0;
        if (busB.if_ready) busB.if_req = 1'b0;
      end
    end
    busB.if_req = 1'b0;
    #1;
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      vectors++;
      if (obsQ.size() == 0) begin
        miscompares++;
        $display("FAIL contend_evt: got nothing, required %h", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL contend_evt: got %h, required %h", o, e); end
      end
    end
    vectors++;
    if (obsQ.size() != 0) begin
      miscompares++;
      $display("FAIL contend_extra: got %0d extra events (first %h), required 0", obsQ.size(), obsQ[0]);
      obsQ.delete();
    end
  endtask

  task automatic test_back_to_back();
    evt_t e, o;
    int nRdy;
    startCycle();
    busB.d_req = 1'b1; busB.d_we = 1'b0; busB.d_addr = 11'h001;
    pushExp(1, 1, 16'h0, 16'h5001, 2);
    pushExp(1, 1, 16'h0, 16'h5002, 5);
    pushExp(1, 2, 16'h030, 16'h7777, 7);
    pushExp(1, 1, 16'h0, 16'h5002, 8);
    nRdy = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++;
      if (busB.mem_en !== (k == 1 || k == 4 || k == 7)) begin
        miscompares++;
        $display("FAIL b2b_mem_en cycle %0d: got %b, required %b", k, busB.mem_en, (k == 1 || k == 4 || k == 7));
      end
      if (busB.d_ready) begin
        nRdy++;
        if (nRdy == 1) begin
          busB.d_addr = 11'h002;
        end else if (nRdy == 2) begin
          busB.d_we = 1'b1; busB.d_addr = 11'h030; busB.d_wdata = 16'h7777;
        end else begin
          busB.d_req = 1'b0; busB.d_we = 1'b0;
        end
      end
    end
    vectors++;
    if (busB.d_rdata !== 16'h5002) begin
      miscompares++;
      $display("FAIL b2b_hold: got %h, required 5002", busB.d_rdata);
    end
    #1;
    while (expQ.size() != 0) begin
      e = expQ.pop_front();
      vectors++;
      if (obsQ.size() == 0) begin
        miscompares++;
        $display("FAIL b2b_evt: got nothing, required %h", e);
      end else begin
        o = obsQ.pop_front();
        if (o !== e) begin miscompares++; $display("FAIL b2b_evt: got %h, required %h", o, e); end
      end
    end
    vectors++;
    if (obsQ.size() != 0) begin
      miscompares++;
      $display("FAIL b2b_extra: got %0d extra events (first %h), required 0", obsQ.size(), obsQ[0]);
      obsQ.delete();
    end
  endtask

  initial begin
    reset = 1'b1;
    memInit = 1'b1;
    busA.if_req = 1'b1; busA.if_addr = 11'h7FF;
    busA.d_req = 1'b1; busA.d_we = 1'b1; busA.d_addr = 11'h7FF; busA.d_wdata = 16'hFFFF;
    busB.if_req = 1'b1; busB.if_addr = 11'h7FF;
    busB.d_req = 1'b1; busB.d_we = 1'b1; busB.d_addr = 11'h7FF; busB.d_wdata = 16'hFFFF;
    test_reset();
    test_store();
    test_fetch();
    test_reset_mid_access();
    test_contention();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
